axi_lite_rr_arbiter: RTL

Two-master to one-slave AXI4-Lite arbiter that shares the memory-side port between IFU (m0) and LSU (m1). Read and write channels are arbitered independently, each by its own FSM with round-robin fairness. A grant is held from address acceptance until the response handshake completes. It sits between the fetch/load-store units and the downstream address decoder / SRAM path.

---
 rtl/axi_lite_rr_arbiter.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_rr_arbiter.sv
// Two-master (m0 = IFU, m1 = LSU) to one-slave AXI4-Lite arbiter.
// The read and write channels are arbitrated independently, with round-robin fairness on each.
// A grant is held from address acceptance until the response handshake completes.
module axi_lite_rr_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned STRB_W = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  // master 0 read
  input  logic [ADDR_W-1:0] m0_araddr_i,
  input  logic              m0_arvalid_i,
  output logic              m0_arready_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic [1:0]        m0_rresp_o,
  output logic              m0_rvalid_o,
  input  logic              m0_rready_i,
  // master 0 write
  input  logic [ADDR_W-1:0] m0_awaddr_i,
  input  logic              m0_awvalid_i,
  output logic              m0_awready_o,
  input  logic [DATA_W-1:0] m0_wdata_i,
  input  logic [STRB_W-1:0] m0_wstrb_i,
  input  logic              m0_wvalid_i,
  output logic              m0_wready_o,
  output logic [1:0]        m0_bresp_o,
  output logic              m0_bvalid_o,
  input  logic              m0_bready_i,
  // master 1 read
  input  logic [ADDR_W-1:0] m1_araddr_i,
  input  logic              m1_arvalid_i,
  output logic              m1_arready_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic [1:0]        m1_rresp_o,
  output logic              m1_rvalid_o,
  input  logic              m1_rready_i,
  // master 1 write
  input  logic [ADDR_W-1:0] m1_awaddr_i,
  input  logic              m1_awvalid_i,
  output logic              m1_awready_o,
  input  logic [DATA_W-1:0] m1_wdata_i,
  input  logic [STRB_W-1:0] m1_wstrb_i,
  input  logic              m1_wvalid_i,
  output logic              m1_wready_o,
  output logic [1:0]        m1_bresp_o,
  output logic              m1_bvalid_o,
  input  logic              m1_bready_i,
  // slave read
  output logic [ADDR_W-1:0] s_araddr_o,
  output logic              s_arvalid_o,
  input  logic              s_arready_i,
  input  logic [DATA_W-1:0] s_rdata_i,
  input  logic [1:0]        s_rresp_i,
  input  logic              s_rvalid_i,
  output logic              s_rready_o,
  // slave write
  output logic [ADDR_W-1:0] s_awaddr_o,
  output logic              s_awvalid_o,
  input  logic              s_awready_i,
  output logic [DATA_W-1:0] s_wdata_o,
  output logic [STRB_W-1:0] s_wstrb_o,
  output logic              s_wvalid_o,
  input  logic              s_wready_i,
  input  logic [1:0]        s_bresp_i,
  input  logic              s_bvalid_i,
  output logic              s_bready_o
);

  typedef enum logic [1:0] {StRIdle, StRAddr, StRData} rd_state_e;
  typedef enum logic [1:0] {StWIdle, StWReq, StWResp} wr_state_e;

  rd_state_e rd_state_q, rd_state_d;
  wr_state_e wr_state_q, wr_state_d;
  // Grant and last-served indices: 0 = m0, 1 = m1.
  logic      rg_q, rg_d, rd_last_q, rd_last_d;
  logic      wg_q, wg_d, wr_last_q, wr_last_d;
  logic      aw_done_q, aw_done_d, w_done_q, w_done_d;

  logic      rd_win, wr_win, wr_req0, wr_req1;
  logic      ar_fire, r_fire, aw_fire, w_fire, b_fire;

  // On a tie the master that was not served last wins.
  assign rd_win  = (m0_arvalid_i && m1_arvalid_i) ? ~rd_last_q : m1_arvalid_i;
  assign wr_req0 = m0_awvalid_i | m0_wvalid_i;
  assign wr_req1 = m1_awvalid_i | m1_wvalid_i;
  assign wr_win  = (wr_req0 && wr_req1) ? ~wr_last_q : wr_req1;

  assign ar_fire = s_arvalid_o & s_arready_i;
  assign r_fire  = s_rvalid_i & s_rready_o;
  assign aw_fire = s_awvalid_o & s_awready_i;
  assign w_fire  = s_wvalid_o & s_wready_i;
  assign b_fire  = s_bvalid_i & s_bready_o;

  // Read FSM state register; last pointer resets to m1 so that m0 wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_state_q <= StRIdle;
      rg_q       <= 1'b0;
      rd_last_q  <= 1'b1;
    end else begin
      rd_state_q <= rd_state_d;
      rg_q       <= rg_d;
      rd_last_q  <= rd_last_d;
    end
  end

  // Read FSM next state.
  always_comb begin
    rd_state_d = rd_state_q;
    rg_d       = rg_q;
    rd_last_d  = rd_last_q;
    unique case (rd_state_q)
      StRIdle: begin
        if (m0_arvalid_i || m1_arvalid_i) begin
          rg_d       = rd_win;
          rd_state_d = StRAddr;
        end
      end
      StRAddr: if (ar_fire) rd_state_d = StRData;
      StRData: begin
        if (r_fire) begin
          rd_last_d  = rg_q;
          rd_state_d = StRIdle;
        end
      end
      default: rd_state_d = StRIdle;
    endcase
  end

  // Read channel outputs: only the granted master sees the slave.
  always_comb begin
    s_araddr_o   = '0;
    s_arvalid_o  = 1'b0;
    s_rready_o   = 1'b0;
    m0_arready_o = 1'b0;
    m1_arready_o = 1'b0;
    m0_rvalid_o  = 1'b0;
    m1_rvalid_o  = 1'b0;
    m0_rdata_o   = '0;
    m1_rdata_o   = '0;
    m0_rresp_o   = '0;
    m1_rresp_o   = '0;
    unique case (rd_state_q)
      StRAddr: begin
        s_araddr_o  = rg_q ? m1_araddr_i : m0_araddr_i;
        s_arvalid_o = rg_q ? m1_arvalid_i : m0_arvalid_i;
        if (rg_q) m1_arready_o = s_arready_i;
        else      m0_arready_o = s_arready_i;
      end
      StRData: begin
        s_rready_o = rg_q ? m1_rready_i : m0_rready_i;
        if (rg_q) begin
          m1_rvalid_o = s_rvalid_i;
          m1_rdata_o  = s_rdata_i;
          m1_rresp_o  = s_rresp_i;
        end else begin
          m0_rvalid_o = s_rvalid_i;
          m0_rdata_o  = s_rdata_i;
          m0_rresp_o  = s_rresp_i;
        end
      end
      default: ;
    endcase
  end

  // Write FSM state register, including the sticky AW/W completion flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_state_q <= StWIdle;
      wg_q       <= 1'b0;
      wr_last_q  <= 1'b1;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wg_q       <= wg_d;
      wr_last_q  <= wr_last_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  // Write FSM next state; AW and W may complete in either order or together.
  always_comb begin
    wr_state_d = wr_state_q;
    wg_d       = wg_q;
    wr_last_d  = wr_last_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    unique case (wr_state_q)
      StWIdle: begin
        if (wr_req0 || wr_req1) begin
          wg_d       = wr_win;
          wr_state_d = StWReq;
        end
      end
      StWReq: begin
        aw_done_d = aw_done_q | aw_fire;
        w_done_d  = w_done_q | w_fire;
        if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          wr_state_d = StWResp;
        end
      end
      StWResp: begin
        if (b_fire) begin
          wr_last_d  = wg_q;
          wr_state_d = StWIdle;
        end
      end
      default: wr_state_d = StWIdle;
    endcase
  end

  // Write channel outputs; a completed AW or W channel is masked until the response.
  always_comb begin
    s_awaddr_o   = '0;
    s_awvalid_o  = 1'b0;
    s_wdata_o    = '0;
    s_wstrb_o    = '0;
    s_wvalid_o   = 1'b0;
    s_bready_o   = 1'b0;
    m0_awready_o = 1'b0;
    m1_awready_o = 1'b0;
    m0_wready_o  = 1'b0;
    m1_wready_o  = 1'b0;
    m0_bvalid_o  = 1'b0;
    m1_bvalid_o  = 1'b0;
    m0_bresp_o   = '0;
    m1_bresp_o   = '0;
    unique case (wr_state_q)
      StWReq: begin
        s_awaddr_o  = wg_q ? m1_awaddr_i : m0_awaddr_i;
        s_awvalid_o = ~aw_done_q & (wg_q ? m1_awvalid_i : m0_awvalid_i);
        s_wdata_o   = wg_q ? m1_wdata_i : m0_wdata_i;
        s_wstrb_o   = wg_q ? m1_wstrb_i : m0_wstrb_i;
        s_wvalid_o  = ~w_done_q & (wg_q ? m1_wvalid_i : m0_wvalid_i);
        if (wg_q) begin
          m1_awready_o = ~aw_done_q & s_awready_i;
          m1_wready_o  = ~w_done_q & s_wready_i;
        end else begin
          m0_awready_o = ~aw_done_q & s_awready_i;
          m0_wready_o  = ~w_done_q & s_wready_i;
        end
      end
      StWResp: begin
        s_bready_o = wg_q ? m1_bready_i : m0_bready_i;
        if (wg_q) begin
          m1_bvalid_o = s_bvalid_i;
          m1_bresp_o  = s_bresp_i;
        end else begin
          m0_bvalid_o = s_bvalid_i;
          m0_bresp_o  = s_bresp_i;
        end
      end
      default: ;
    endcase
  end

endmodule
